user_module_341431502448362067: RTL and testbench
=================================================

USER_MODULE_341431502448362067 -- requirements
Module: user_module_341431502448362067

Interface
REQ-001 The block SHALL have no HDL parameters; all variation is via the macro in Configuration.
REQ-002 io_in[0]  input  1  clk; rising-edge clock for all state.
REQ-003 io_in[1]  input  1  rst_n; reset, asynchronous, active-low.
REQ-004 io_in[2]  input  1  b_in; serial operand B bit, LSB first.
REQ-005 io_in[3]  input  1  a_in; serial operand A bit, LSB first.
REQ-006 io_in[6:4]  input  3  op; operation select, sampled on the frame-completing edge.
REQ-007 io_in[7]  input  1  en; bit-shift enable; 0 = pause, all state held.
REQ-008 io_out[7:0]  output  8  result; registered 8-bit result of the last completed frame.

Function
REQ-009 The block SHALL be an 8-bit bit-serial ALU: each rising clk with en=1 SHALL shift a_in into 8-bit register A and b_in into register B, LSB first (shift right, new bit enters bit 7), and increment a 3-bit counter.
REQ-010 A frame SHALL complete on the en=1 edge where the counter is 7; the counter SHALL then wrap to 0.
REQ-011 On frame completion, io_out SHALL load f(op, A', B') on that same edge, where A'/B' include the bit shifted in on that edge (latency: result visible immediately after the 8th bit edge).
REQ-012 op encoding: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 100 A^B; 101 A<<B[2:0]; 110 A>>B[2:0] (logical); 111 {7'b0, A<B unsigned}.
REQ-013 All arithmetic SHALL be modulo 256; carry/borrow discarded (0xFF+0x01=0x00, 0x00-0x01=0xFF).
REQ-014 Outside frame completion, io_out SHALL hold its value.
REQ-015 With en=0, A, B, counter and io_out SHALL hold; a frame paused mid-way SHALL resume at the held bit position when en returns to 1.
REQ-016 op changes between frame-completing edges SHALL have no effect.

Reset
REQ-017 rst_n=0 SHALL immediately (asynchronously) clear A, B, counter and io_out to 0, regardless of clk or en.
REQ-018 Reset asserted mid-frame SHALL discard the partial frame; after release the next en=1 edge SHALL be bit 0 of a new frame.
REQ-019 Reset release SHALL be treated synchronously to clk by the surrounding system; no internal synchronizer is required.

Configuration
REQ-020 Macro ALU_SHIFT_OPS_EN: when defined, op 101/110 SHALL perform shifts per REQ-012.
REQ-021 When ALU_SHIFT_OPS_EN is undefined, op 101/110 SHALL produce io_out=0x00 and no shifter logic SHALL be synthesized; all other ops unchanged.

Verification
REQ-022 Reset, en=1, op=000, shift A=0x35, B=0x0F over 8 clocks -> io_out=0x00 before 8th edge, 0x44 after it.
REQ-023 op=000, A=0xFF, B=0x01 -> io_out=0x00; then op=001, A=0x00, B=0x01 -> io_out=0xFF.
REQ-024 op=010/011/100 with A=0xC3, B=0x5A -> 0x42 / 0xDB / 0x99 respectively.
REQ-025 With ALU_SHIFT_OPS_EN defined, op=101, A=0x81, B=0x03 -> 0x08; op=110 same operands -> 0x10; macro undefined -> 0x00 for both.
REQ-026 Shift 4 bits, hold en=0 for 5 clocks, then 4 more bits of A=0x12, B=0x34, op=111 -> io_out=0x01, updated only on the 8th enabled edge.
REQ-027 Shift 4 bits, pulse rst_n low between edges -> io_out=0x00 immediately; then full frame A=0x10, B=0x01, op=001 -> io_out=0x0F.

Source files
------------

// File: rtl/user_module_341431502448362067.sv
// user_module_341431502448362067: 8-bit bit-serial ALU, LSB-first operands, result loaded on the 8th enabled edge.
// Define ALU_SHIFT_OPS_EN to build the shift ops (101/110); without it they return 0x00.
module user_module_341431502448362067 (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  logic       clk, rst_n, b_in, a_in, en;
  logic [2:0] op, cnt;
  logic [7:0] a, b, a_n, b_n, shl, shr, res;
  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign b_in  = io_in[2];
  assign a_in  = io_in[3];
  assign op    = io_in[6:4];
  assign en    = io_in[7];
  // Operands as they stand after this edge's shift, so the result includes the final bit.
  assign a_n = {a_in, a[7:1]};
  assign b_n = {b_in, b[7:1]};
`ifdef ALU_SHIFT_OPS_EN
  assign shl = a_n << b_n[2:0];
  assign shr = a_n >> b_n[2:0];
`else
  assign shl = '0;
  assign shr = '0;
`endif
  always_comb
    res = op == 3'd0 ? a_n + b_n :
          op == 3'd1 ? a_n - b_n :
          op == 3'd2 ? a_n & b_n :
          op == 3'd3 ? a_n | b_n :
          op == 3'd4 ? a_n ^ b_n :
          op == 3'd5 ? shl :
          op == 3'd6 ? shr :
                       {7'b0, a_n < b_n};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      cnt    <= '0;
      io_out <= '0;
    end else if (en) begin
      a   <= a_n;
      b   <= b_n;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) io_out <= res;
    end
endmodule

// File: tb/tb_user_module_341431502448362067.sv
// tb_user_module_341431502448362067: directed-vector bench for the bit-serial ALU.
module tb_user_module_341431502448362067;
  logic       clk = 0, rst_n = 0, a_in = 0, b_in = 0, en = 0;
  logic [2:0] op = 0;
  logic [7:0] io_out;
  logic [7:0] last;
  int n_cmp = 0, n_bad = 0;
  user_module_341431502448362067 dut (
    .io_in ({en, op, a_in, b_in, rst_n, clk}),
    .io_out(io_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask
  task automatic shift_bit(input logic a, input logic b, input logic [2:0] o);
    @(negedge clk);
    a_in = a;
    b_in = b;
    op   = o;
    en   = 1;
    @(posedge clk);
    #1 en = 0;
  endtask
  // Bits lo..hi of a/b; op is inverted except on bit 7 so a non-sampled op would show up.
  task automatic bits(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (i == 7) chk("hold_before_8th", io_out, last);
      shift_bit(a[i], b[i], i == 7 ? o : ~o);
    end
  endtask
  task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [2:0] o, input logic [7:0] exp);
    bits(a, b, o, 0, 7);
    chk(tag, io_out, exp);
    last = exp;
  endtask
  initial begin
    last = 8'h00;
    #2 chk("reset", io_out, 8'h00);
    @(negedge clk) rst_n = 1;
    frame("add_35_0f", 8'h35, 8'h0F, 3'd0, 8'h44);
    frame("add_wrap", 8'hFF, 8'h01, 3'd0, 8'h00);
    frame("sub_borrow", 8'h00, 8'h01, 3'd1, 8'hFF);
    frame("and", 8'hC3, 8'h5A, 3'd2, 8'h42);
    frame("or", 8'hC3, 8'h5A, 3'd3, 8'hDB);
    frame("xor", 8'hC3, 8'h5A, 3'd4, 8'h99);
`ifdef ALU_SHIFT_OPS_EN
    frame("shl", 8'h81, 8'h03, 3'd5, 8'h08);
    frame("shr", 8'h81, 8'h03, 3'd6, 8'h10);
`else
    frame("add_pre_shl", 8'h20, 8'h03, 3'd0, 8'h23);
    frame("shl_off", 8'h81, 8'h03, 3'd5, 8'h00);
    frame("add_pre_shr", 8'h20, 8'h03, 3'd0, 8'h23);
    frame("shr_off", 8'h81, 8'h03, 3'd6, 8'h00);
`endif
    frame("lt_false", 8'h34, 8'h12, 3'd7, 8'h00);
    bits(8'h12, 8'h34, 3'd7, 0, 3);
    repeat (5) @(posedge clk);
    #1 chk("pause_hold", io_out, last);
    bits(8'h12, 8'h34, 3'd7, 4, 7);
    chk("lt_paused", io_out, 8'h01);
    last = 8'h01;
    frame("lt_equal", 8'h55, 8'h55, 3'd7, 8'h00);
    frame("add_small", 8'h01, 8'h01, 3'd0, 8'h02);
    bits(8'hFF, 8'hFF, 3'd0, 0, 3);
    @(negedge clk) rst_n = 0;
    #1 chk("async_reset", io_out, 8'h00);
    #1 rst_n = 1;
    last = 8'h00;
    frame("sub_after_reset", 8'h10, 8'h01, 3'd1, 8'h0F);
    repeat (3) @(posedge clk);
    #1 chk("idle_hold", io_out, 8'h0F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
